// File: rtl/aes_round_pipe.sv
// aes_round_pipe: AES encryption on a 3-slot recirculating ring (A sub_bytes, B shift/mix, C add key).
// Define AES_ROUND_PIPE_STATS_EN to add the blk_count / stall_count outputs.
module aes_round_pipe #(
  parameter int NUM_ROUNDS = 10,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [127:0]     round_key_0,
  output logic [3:0]       round_key_addr,
  input  logic [127:0]     round_key_input,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef AES_ROUND_PIPE_STATS_EN
  ,
  output logic [15:0]      blk_count,
  output logic [15:0]      stall_count
`endif
);

  if (!(NUM_ROUNDS == 10 || NUM_ROUNDS == 12 || NUM_ROUNDS == 14)) begin : g_bad_rounds
    $error("aes_round_pipe: NUM_ROUNDS must be 10, 12 or 14");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[x[8*i +: 8]];
    return r;
  endfunction

  // Byte n of the block is bits [127-8n -: 8]; state[row][col] is byte row+4*col.
  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        r[127-8*(row+4*col) -: 8] = x[127-8*(row+4*((col+row)%4)) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] x);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int col = 0; col < 4; col++) begin
      a0 = x[127-32*col -: 8];
      a1 = x[119-32*col -: 8];
      a2 = x[111-32*col -: 8];
      a3 = x[103-32*col -: 8];
      r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  logic             a_valid, b_valid, c_valid;
  logic [3:0]       a_rnd, b_rnd, c_rnd;
  logic [TAG_W-1:0] a_tag, b_tag, c_tag;
  logic [127:0]     a_blk, b_blk, c_blk;
  logic [127:0]     key_reg;

  logic             c_last, stall, recirc, take;
  logic [127:0]     a_src, a_blk_d, sr_blk, b_blk_d;

  assign c_last = c_valid && (c_rnd == LAST_RND);
  assign recirc = c_valid && (c_rnd != LAST_RND);
  assign stall  = c_last && out_valid && !out_ready;

  assign in_ready = n_rst && !flush && !stall && (!c_valid || (c_rnd == LAST_RND));
  assign take     = in_valid && in_ready;

  assign round_key_addr = n_rst ? a_rnd : 4'd0;

  // One sbox layer serves both new entries and recirculating blocks.
  assign a_src   = recirc ? c_blk : (in_data ^ round_key_0);
  assign a_blk_d = sub_bytes(a_src);
  assign sr_blk  = shift_rows(a_blk);
  assign b_blk_d = (a_rnd == LAST_RND) ? sr_blk : mix_columns(sr_blk);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      a_valid <= 1'b0;  a_rnd <= '0;  a_tag <= '0;  a_blk <= '0;
      b_valid <= 1'b0;  b_rnd <= '0;  b_tag <= '0;  b_blk <= '0;
      c_valid <= 1'b0;  c_rnd <= '0;  c_tag <= '0;  c_blk <= '0;
      key_reg <= '0;
    end else if (flush) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      c_valid <= 1'b0;
    end else if (!stall) begin
      a_valid <= recirc || take;
      a_rnd   <= recirc ? 4'(c_rnd + 4'd1) : (take ? 4'd1 : 4'd0);
      a_tag   <= recirc ? c_tag : in_tag;
      a_blk   <= a_blk_d;

      b_valid <= a_valid;
      b_rnd   <= a_rnd;
      b_tag   <= a_tag;
      b_blk   <= b_blk_d;
      key_reg <= round_key_input;

      c_valid <= b_valid;
      c_rnd   <= b_rnd;
      c_tag   <= b_tag;
      c_blk   <= b_blk ^ key_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (c_last && !stall) begin
      out_valid <= 1'b1;
      out_data  <= c_blk;
      out_tag   <= c_tag;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef AES_ROUND_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (!n_rst || flush) begin
      blk_count   <= '0;
      stall_count <= '0;
    end else begin
      if (out_valid && out_ready) blk_count <= blk_count + 16'd1;
      if (stall && (stall_count != 16'hffff)) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_pipe.sv
// Scoreboard bench: three ring instances (10/12/14 rounds) checked against a whole-cipher AES model.
module tb_aes_round_pipe;
  localparam int TAG_W = 4;
  localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;

  typedef struct packed {
    logic [127:0]     d;
    logic [TAG_W-1:0] t;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             n_rst, flush, out_ready;
  logic [127:0]     in_data;
  logic [TAG_W-1:0] in_tag;
  logic             in_valid  [3];
  logic             in_ready  [3];
  logic [3:0]       rk_addr   [3];
  logic [127:0]     rk_in     [3];
  logic             out_valid [3];
  logic [127:0]     out_data  [3];
  logic [TAG_W-1:0] out_tag   [3];
`ifdef AES_ROUND_PIPE_STATS_EN
  logic [15:0]      blk_count   [3];
  logic [15:0]      stall_count [3];
`endif

  logic [127:0] rk [3][16];
  logic [7:0]   sb [256];
  exp_t         q  [3][$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  int           acc_cyc;
  bit           done;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rk_in[g] = rk[g][rk_addr[g]];
    aes_round_pipe #(.NUM_ROUNDS(10 + 2*g), .TAG_W(TAG_W)) dut (
      .clk(clk), .n_rst(n_rst), .flush(flush),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_data(in_data), .in_tag(in_tag),
      .round_key_0(rk[g][0]), .round_key_addr(rk_addr[g]), .round_key_input(rk_in[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready),
      .out_data(out_data[g]), .out_tag(out_tag[g])
`ifdef AES_ROUND_PIPE_STATS_EN
      , .blk_count(blk_count[g]), .stall_count(stall_count[g])
`endif
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic int nr_of(input int d);
    return 10 + 2*d;
  endfunction

  // Build the S-box from first principles: GF(2^8) inverse followed by the affine map.
  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  task automatic set_key(input int d, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr, nk;
    nr = nr_of(d);
    nk = (nr == 10) ? 4 : ((nr == 12) ? 6 : 8);
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]});
          t[31:24] = t[31:24] ^ rc;
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) rk[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input int d, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    int nr;
    nr = nr_of(d);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[d][0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[w+4*c] = s[w+4*((c+w)%4)];
      for (int c = 0; c < 4; c++) begin
        if (r < nr) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          s[4*c] = t[4*c]; s[4*c+1] = t[4*c+1]; s[4*c+2] = t[4*c+2]; s[4*c+3] = t[4*c+3];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[d][r][127-8*i -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Output monitor: every presented block is compared with the head of its queue.
  always @(negedge clk) begin
    if (n_rst) begin
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d]) begin
          if (q[d].size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_out dut%0d: got data %h tag %0d, expected no output", d, out_data[d], out_tag[d]);
          end else begin
            chk($sformatf("out_data_dut%0d", d), out_data[d], q[d][0].d);
            chk($sformatf("out_tag_dut%0d", d), 128'(out_tag[d]), 128'(q[d][0].t));
            if (out_ready) void'(q[d].pop_front());
          end
        end
      end
    end
  end

  task automatic send_exp(input int d, input logic [127:0] data, input logic [TAG_W-1:0] tag,
                          input logic [127:0] ct);
    exp_t e;
    in_data = data; in_tag = tag; in_valid[d] = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        @(posedge clk); #1;
        acc_cyc = cyc;
        e.d = ct; e.t = tag;
        q[d].push_back(e);
        in_valid[d] = 1'b0;
        return;
      end
    end
    in_valid[d] = 1'b0;
    n_tests++; n_fail++;
    $display("FAIL send_timeout dut%0d: in_ready never rose, expected acceptance", d);
  endtask

  task automatic send(input int d, input logic [127:0] data, input logic [TAG_W-1:0] tag);
    send_exp(d, data, tag, aes_enc(d, data));
  endtask

  task automatic drain(input int d);
    int n;
    for (n = 0; n < 3000 && q[d].size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk($sformatf("drain_dut%0d_left", d), 128'(q[d].size()), 128'd0);
  endtask

  task automatic wait_out(input int d);
    int n;
    for (n = 0; n < 300 && !out_valid[d]; n++) begin
      @(posedge clk); #1;
    end
    chk("wait_out_valid", 128'(out_valid[d]), 128'd1);
  endtask

  // Latency counts the accepting edge as edge 1.
  task automatic kat(input int d, input logic [255:0] key, input logic [127:0] ct);
    int lat;
    set_key(d, key);
    send_exp(d, PT_C, 4'd5, ct);
    lat = 1;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid[d]) break;
    end
    chk($sformatf("kat_latency_dut%0d", d), 128'(lat), 128'(3*nr_of(d) + 1));
    drain(d);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rnd_run(input int d, input int nblk);
    set_key(d, {rnd128(), rnd128()});
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < nblk; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          send(d, rnd128(), TAG_W'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain(d);
  endtask

  initial begin
    int acc [4];
    int seen;
    logic [127:0] d0, ct0;
    init_sbox();
    for (int d = 0; d < 3; d++) for (int r = 0; r < 16; r++) rk[d][r] = '0;
    n_rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_data = '0; in_tag = '0;
    for (int d = 0; d < 3; d++) in_valid[d] = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready[0]), 128'd0);
    chk("rst_key_addr", 128'(rk_addr[0]), 128'd0);
    chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("rst_out_data", out_data[0], 128'd0);
    chk("rst_out_tag", 128'(out_tag[0]), 128'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    kat(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    kat(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
        128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    kat(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
        128'h8ea2b7ca516745bfeafc49904b496089);

    // Back-to-back fill, then a fourth block that must wait for the first completion.
    set_key(0, {rnd128(), rnd128()});
    for (int i = 0; i < 4; i++) begin
      send(0, rnd128(), TAG_W'(i + 1));
      acc[i] = acc_cyc;
    end
    chk("b2b_gap_1", 128'(acc[1] - acc[0]), 128'd1);
    chk("b2b_gap_2", 128'(acc[2] - acc[1]), 128'd1);
    chk("ring_full_wait", 128'(acc[3] - acc[0]), 128'd30);
    drain(0);

    // Backpressure with three blocks in flight.
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    out_ready = 1'b0;
    d0 = rnd128();
    ct0 = aes_enc(0, d0);
    send(0, d0, 4'd6);
    send(0, rnd128(), 4'd7);
    send(0, rnd128(), 4'd8);
    wait_out(0);
    for (int i = 0; i < 20; i++) begin
      chk("stall_out_data", out_data[0], ct0);
      chk("stall_out_tag", 128'(out_tag[0]), 128'd6);
      chk("stall_in_ready", 128'(in_ready[0]), 128'd0);
      chk("stall_key_addr", 128'(rk_addr[0]), 128'd0);
      @(posedge clk); #1;
    end
`ifdef AES_ROUND_PIPE_STATS_EN
    chk("stall_count", 128'(stall_count[0]), 128'd20);
`endif
    out_ready = 1'b1;
    drain(0);

    // Flush with two blocks in flight and a competing in_valid.
    send(0, rnd128(), 4'd9);
    acc[0] = acc_cyc;
    send(0, rnd128(), 4'd10);
    while (cyc < acc[0] + 9) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid[0] = 1'b1; in_data = rnd128(); in_tag = 4'd11;
    @(negedge clk);
    chk("flush_in_ready", 128'(in_ready[0]), 128'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid[0] = 1'b0;
    q[0].delete();
    chk("flush_out_valid", 128'(out_valid[0]), 128'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid[0]) seen++; end
    chk("flush_no_output", 128'(seen), 128'd0);
    kat(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // Reset mid-operation while an output is held.
    set_key(0, {rnd128(), rnd128()});
    out_ready = 1'b0;
    send(0, rnd128(), 4'd12);
    send(0, rnd128(), 4'd13);
    wait_out(0);
    repeat (3) begin @(posedge clk); #1; end
    n_rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 128'(in_ready[0]), 128'd0);
    chk("midrst_key_addr", 128'(rk_addr[0]), 128'd0);
    @(posedge clk); #1;
    chk("midrst_out_valid", 128'(out_valid[0]), 128'd0);
    chk("midrst_out_data", out_data[0], 128'd0);
    chk("midrst_out_tag", 128'(out_tag[0]), 128'd0);
    n_rst = 1'b1;
    q[0].delete();
    out_ready = 1'b1;
    seen = 0;
    repeat (100) begin @(posedge clk); #1; if (out_valid[0]) seen++; end
    chk("midrst_no_stale", 128'(seen), 128'd0);

    rnd_run(0, 30);
    rnd_run(1, 12);
    rnd_run(2, 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/aes_round_pipe.md
AES_ROUND_PIPE -- requirements
Module: aes_round_pipe

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, meaning the AES round count; legal values are 10, 12 and 14, and any other value SHALL fail elaboration.
REQ-002 The block SHALL have parameter TAG_W, default 4, meaning the width of the sideband tag carried with each block.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port n_rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port flush, input, 1 bit: synchronous discard of all in-flight blocks.
REQ-006 Port in_valid, input, 1 bit: a plaintext block is offered.
REQ-007 Port in_ready, output, 1 bit: the offered block is accepted on this edge.
REQ-008 Port in_data, input, 128 bits: the plaintext block.
REQ-009 Port in_tag, input, TAG_W bits: the tag for the plaintext block.
REQ-010 Port round_key_0, input, 128 bits: the initial whitening key.
REQ-011 Port round_key_addr, output, 4 bits: the index of the round key requested.
REQ-012 Port round_key_input, input, 128 bits: the key for round_key_addr, sampled on the next edge.
REQ-013 Port out_valid, output, 1 bit: a ciphertext block is presented.
REQ-014 Port out_ready, input, 1 bit: the consumer accepts the presented block.
REQ-015 Port out_data, output, 128 bits: the ciphertext block.
REQ-016 Port out_tag, output, TAG_W bits: the tag returned with the ciphertext block.

Function
REQ-017 The datapath SHALL be a 3-slot recirculating ring, A then B then C then back to A; each slot holds valid, rnd (4 bits), tag and a 128-bit block.
- Up to 3 blocks may be in flight.
REQ-018 Stage A load SHALL behave as follows:
- On a new block: block = sub_bytes(in_data XOR round_key_0), rnd = 1.
- On recirculation from C: block = sub_bytes(C.block), rnd = C.rnd + 1.
REQ-019 Stage B load SHALL be mix_columns(shift_rows(A.block)) when A.rnd < NUM_ROUNDS, and shift_rows(A.block) only when A.rnd == NUM_ROUNDS.
REQ-020 Stage C load SHALL be B.block XOR key_reg, with rnd and tag passed through unchanged.
REQ-021 The round key path SHALL work as follows:
- round_key_addr = A.rnd, combinational from the A register.
- key_reg captures round_key_input whenever B loads.
REQ-022 Completion: a valid C slot with rnd == NUM_ROUNDS SHALL move to the output register (out_data, out_tag, out_valid) and SHALL NOT recirculate.
REQ-023 The stall term SHALL be stall = C.valid AND C.rnd == NUM_ROUNDS AND out_valid AND NOT out_ready.
- While stall is high, slots A, B, C and key_reg SHALL hold.
REQ-024 The input handshake SHALL be in_ready = n_rst AND NOT flush AND NOT stall AND (NOT C.valid OR C.rnd == NUM_ROUNDS).
- A transfer occurs on an edge where in_valid AND in_ready.
- in_ready SHALL NOT depend combinationally on in_valid.
REQ-025 A slot that is not refilled (no transfer, no recirculation) SHALL load valid = 0.
REQ-026 The output register SHALL behave as follows:
- out_valid rises when a completing block arrives.
- out_valid falls on out_valid AND out_ready with no new arrival.
- Simultaneous drain and arrival SHALL load the new block with out_valid held high.
- out_data and out_tag SHALL be stable while out_valid AND NOT out_ready.
REQ-027 Latency SHALL be 3*NUM_ROUNDS+1 edges from the accepting edge to the edge raising out_valid, absent stall; this is 31 edges for NUM_ROUNDS = 10.
REQ-028 Ordering: blocks SHALL complete in acceptance order.
REQ-029 Throughput SHALL be at most 3 blocks per 3*NUM_ROUNDS cycles; a new block enters only into a free ring position.
REQ-030 Flush SHALL, on the next edge, clear all slot valids and out_valid.
- in_ready SHALL be low while flush is high.
- Flush SHALL win over a simultaneous in_valid, completion or out_ready.

Reset
REQ-031 While n_rst is low at an edge, the block SHALL clear all slot valids, rnd, blocks, tags, key_reg, out_valid, out_data and out_tag to 0.
REQ-032 During reset, in_ready SHALL be 0 and round_key_addr SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight and output blocks, with no partial result emitted afterwards.

Configuration
REQ-034 With macro AES_ROUND_PIPE_STATS_EN defined, the block SHALL add the following outputs:
- blk_count (16 bits): increments on each out_valid AND out_ready and wraps 0xFFFF to 0.
- stall_count (16 bits): increments on each stall cycle and saturates at 0xFFFF.
- Both counters clear on reset and on flush.
REQ-035 With AES_ROUND_PIPE_STATS_EN undefined, these ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-036 Single block, NUM_ROUNDS = 10, FIPS-197 C.1 (key 000102..0f, pt 00112233445566778899aabbccddeeff, tag 5, out_ready = 1) -> out 69c4e0d86a7b0430d8cdb78070b4c55a, tag 5, out_valid exactly 31 edges after acceptance.
REQ-037 NUM_ROUNDS = 12 (C.2) -> out dda97ca4864cdfe06eaf70a0ec0d7191; NUM_ROUNDS = 14 (C.3) -> out 8ea2b7ca516745bfeafc49904b496089.
REQ-038 Three back-to-back blocks with tags 1, 2, 3 and in_valid held high -> accepted on consecutive edges; in_ready low until the ring frees a position; outputs in tag order 1, 2, 3 with correct ciphertexts.
REQ-039 Backpressure: out_ready = 0 for 20 cycles with 3 blocks in flight -> out_data and out_tag stable, ring frozen, in_ready = 0 and stall_count = 20 (if enabled); after release, all 3 outputs are correct.
REQ-040 Flush asserted at cycle 10 with 2 blocks in flight and in_valid = 1 -> no output is produced, in_ready is low during flush, and a subsequent C.1 block yields the correct result at 31-edge latency.
REQ-041 n_rst low for one edge mid-operation -> all outputs 0 next cycle and no stale output afterwards.
